payoff_accum: RTL and testbench

//   Monte-Carlo payoff stage directly downstream of the path generator. Takes
//   one 12-bit unsigned fixed-point price per valid cycle (8 int, 4 frac bits),

---
 rtl/payoff_accum.sv | 151 +++++++++++++++
 tb/tb_payoff_accum.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/payoff_accum.sv
// Monte-Carlo European payoff accumulator: counts days per path, adds max(S-K,0)/max(K-S,0) per path, publishes sum and mean.
// Latency: expiry sample at edge E -> path_done/done/payoff_sum/price_mean visible after E (1 cycle, registered outputs).
// Backpressure: none; path_valid is accepted every cycle in RUN, gaps of any length allowed, ignored outside RUN.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   start               pulse, begins a run from IDLE; latches is_call and strike
//   is_call, strike     option type (1=call) and strike K (Q8.4 unsigned)
//   path_valid, path    one simulated price S (Q8.4 unsigned) per valid cycle
//   busy                high while in RUN
//   path_done           1-cycle pulse after each path's expiry sample
//   done                1-cycle pulse; payoff_sum/price_mean valid from this cycle
//   payoff_sum          sum of all payoffs of the last run
//   price_mean          payoff_sum >> LOG2_PATHS, low 12 bits (floor)
module payoff_accum #(
    parameter int N_DAYS     = 16,
    parameter int LOG2_PATHS = 8,
    parameter int ACC_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_call,
    input  logic [11:0]      strike,
    input  logic             path_valid,
    input  logic [11:0]      path,
    output logic             busy,
    output logic             path_done,
    output logic             done,
    output logic [ACC_W-1:0] payoff_sum,
    output logic [11:0]      price_mean
);

    localparam int DAY_W = (N_DAYS > 1) ? $clog2(N_DAYS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DAY_W-1:0]      day_cnt_q, day_cnt_d;
    logic [LOG2_PATHS-1:0] path_cnt_q, path_cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [ACC_W-1:0]      sum_q, sum_d;
    logic [11:0]           mean_q, mean_d;
    logic                  busy_q, busy_d;
    logic                  path_done_q, path_done_d;
    logic                  done_q, done_d;
    logic [11:0]           strike_q, strike_d;
    logic                  is_call_q, is_call_d;

    logic [11:0]           payoff;
    logic [ACC_W-1:0]      acc_next;

    always_comb begin
        // S==K yields 0 for both option types
        payoff = 12'd0;
        if (is_call_q) begin
            if (path > strike_q) payoff = path - strike_q;
        end else begin
            if (strike_q > path) payoff = strike_q - path;
        end
        // zero-extend; ACC_W >= 12+LOG2_PATHS so this never wraps
        acc_next = acc_q + {{(ACC_W-12){1'b0}}, payoff};
    end

    always_comb begin
        state_d     = state_q;
        day_cnt_d   = day_cnt_q;
        path_cnt_d  = path_cnt_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        mean_d      = mean_q;
        strike_d    = strike_q;
        is_call_d   = is_call_q;
        path_done_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    strike_d   = strike;
                    is_call_d  = is_call;
                    acc_d      = '0;
                    day_cnt_d  = '0;
                    path_cnt_d = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (path_valid) begin
                    if (day_cnt_q == DAY_W'(N_DAYS - 1)) begin
                        day_cnt_d   = '0;
                        acc_d       = acc_next;
                        path_done_d = 1'b1;
                        path_cnt_d  = path_cnt_q + LOG2_PATHS'(1);
                        // publish on the same edge as the final accumulate so
                        // done and the results appear together
                        if (path_cnt_q == '1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            sum_d   = acc_next;
                            mean_d  = acc_next[LOG2_PATHS+11:LOG2_PATHS];
                        end
                    end else begin
                        day_cnt_d = day_cnt_q + DAY_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            day_cnt_q   <= '0;
            path_cnt_q  <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            mean_q      <= '0;
            busy_q      <= 1'b0;
            path_done_q <= 1'b0;
            done_q      <= 1'b0;
            strike_q    <= '0;
            is_call_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            day_cnt_q   <= day_cnt_d;
            path_cnt_q  <= path_cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            mean_q      <= mean_d;
            busy_q      <= busy_d;
            path_done_q <= path_done_d;
            done_q      <= done_d;
            strike_q    <= strike_d;
            is_call_q   <= is_call_d;
        end
    end

    assign busy       = busy_q;
    assign path_done  = path_done_q;
    assign done       = done_q;
    assign payoff_sum = sum_q;
    assign price_mean = mean_q;

endmodule

// File: tb/tb_payoff_accum.sv
// Testbench for payoff_accum with N_DAYS=4, LOG2_PATHS=2, ACC_W=14.
// Latency: checks outputs #1 after every rising edge.
// Backpressure: none; inserts random path_valid gaps and stray start pulses.
module tb_payoff_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        is_call = 1'b0;
    logic [11:0] strike = 12'd0;
    logic        path_valid = 1'b0;
    logic [11:0] path = 12'd0;
    logic        busy, path_done, done;
    logic [13:0] payoff_sum;
    logic [11:0] price_mean;

    payoff_accum #(.N_DAYS(4), .LOG2_PATHS(2), .ACC_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_call(is_call),
        .strike(strike), .path_valid(path_valid), .path(path),
        .busy(busy), .path_done(path_done), .done(done),
        .payoff_sum(payoff_sum), .price_mean(price_mean)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             is_call;
        logic [11:0]      k;
        logic [3:0][11:0] s;     // expiry price of each path
        logic [13:0]      sum;
        logic [11:0]      mean;
    } vec_t;

    typedef struct packed {
        logic [13:0] sum;
        logic [11:0] mean;
    } res_t;

    vec_t tbl[5];
    res_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // reference view of the block: 0=IDLE 1=RUN 2=DONE
    int          m_state = 0;
    int          m_day = 0;
    int          m_path = 0;
    logic [13:0] m_sum = '0;
    logic [11:0] m_mean = '0;
    int          pd_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the reference, compare after the edge.
    task automatic step(input logic v, input logic [11:0] s, input logic st);
        logic exp_pd, exp_done;
        res_t r;
        path_valid = v;
        path       = s;
        start      = st;
        exp_pd     = 1'b0;
        exp_done   = 1'b0;
        case (m_state)
            0: if (st) begin m_state = 1; m_day = 0; m_path = 0; end
            1: if (v) begin
                if (m_day == 3) begin
                    m_day  = 0;
                    exp_pd = 1'b1;
                    if (m_path == 3) begin m_state = 2; exp_done = 1'b1; end
                    m_path = m_path + 1;
                end else begin
                    m_day = m_day + 1;
                end
            end
            default: m_state = 0;
        endcase
        @(posedge clk);
        #1;
        if (path_done === 1'b1) pd_seen++;
        check("busy", busy, (m_state == 1));
        check("path_done", path_done, exp_pd);
        check("done", done, exp_done);
        if (exp_done) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard: got done with empty queue expected entry");
            end else begin
                r = sb.pop_front();
                m_sum  = r.sum;
                m_mean = r.mean;
            end
        end
        check("payoff_sum", payoff_sum, m_sum);
        check("price_mean", price_mean, m_mean);
        start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        start = 1'b1;                 // reset must win over start/valid
        path_valid = 1'b1;
        path = 12'hFFF;
        repeat (n) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_path_done", path_done, 0);
        check("rst_done", done, 0);
        check("rst_payoff_sum", payoff_sum, 0);
        check("rst_price_mean", price_mean, 0);
        rst_n = 1'b1;
        start = 1'b0;
        path_valid = 1'b0;
        m_state = 0; m_day = 0; m_path = 0;
        m_sum = '0; m_mean = '0;
        sb.delete();
    endtask

    // Full run of table entry idx; gaps adds idle cycles and stray starts.
    task automatic run_vec(input int idx, input bit gaps);
        logic [11:0] s;
        step(1'b1, 12'h123, 1'b0);          // path_valid in IDLE is ignored
        is_call = tbl[idx].is_call;
        strike  = tbl[idx].k;
        step(1'b0, 12'h000, 1'b1);
        is_call = ~tbl[idx].is_call;        // latched values must be used
        strike  = 12'($urandom_range(0, 4095));
        pd_seen = 0;
        for (int p = 0; p < 4; p++) begin
            for (int d = 0; d < 4; d++) begin
                if (gaps) begin
                    int g = $urandom_range(0, 2);
                    for (int i = 0; i < g; i++)
                        step(1'b0, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
                end
                s = (d == 3) ? tbl[idx].s[p] : 12'($urandom_range(0, 4095));
                if (p == 3 && d == 3) sb.push_back({tbl[idx].sum, tbl[idx].mean});
                step(1'b1, s, gaps ? 1'($urandom_range(0, 1)) : 1'b0);
            end
        end
        step(1'b1, 12'hFFF, gaps);          // DONE cycle: start/valid ignored
        step(1'b1, 12'hFFF, 1'b0);          // IDLE: valid ignored
        check("path_done_count", pd_seen, 4);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 12'h0A0, {12'h0B8, 12'h080, 12'h0A0, 12'h0C0}, 14'h0038, 12'h00E};
        tbl[1] = '{1'b0, 12'h0A0, {12'h0B8, 12'h080, 12'h0A0, 12'h0C0}, 14'h0020, 12'h008};
        tbl[2] = '{1'b1, 12'h000, {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 14'h3FFC, 12'hFFF};
        tbl[3] = '{1'b0, 12'hFFF, {12'h000, 12'h000, 12'h000, 12'h000}, 14'h3FFC, 12'hFFF};
        tbl[4] = '{1'b0, 12'h100, {12'h0F0, 12'h000, 12'h100, 12'h0FF}, 14'h0111, 12'h044};

        do_reset(2);
        for (int i = 0; i < 5; i++) run_vec(i, 1'b0);

        // reset mid-run: no done, all outputs cleared, block back in IDLE
        is_call = 1'b1; strike = 12'h0A0;
        step(1'b0, 12'h0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 12'h0C0, 1'b0);
        do_reset(2);
        for (int i = 0; i < 5; i++) step(1'b1, 12'hFFF, 1'b0);

        // gaps and stray starts give identical results
        run_vec(0, 1'b1);
        run_vec(1, 1'b1);
        run_vec(4, 1'b1);
        for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 12'h555, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
